// File: rtl/lsu_ram_master.sv
// lsu_ram_master: byte-addressed load/store master for a word RAM.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_ram_master #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32,
  localparam int AW = $clog2(TAM_POSICIONES)
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   REQ,
  input  logic                   WE,
  input  logic [2:0]             FUNCT3,
  input  logic [31:0]            ADDR,
  input  logic [TAM_PALABRA-1:0] WDATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic [TAM_PALABRA-1:0] RDATA,
  output logic                   RAM_WR,
  output logic                   RAM_OE,
  output logic [AW-1:0]          RAM_ADDRESS,
  output logic [TAM_PALABRA-1:0] RAM_DATA_IN,
  input  logic [TAM_PALABRA-1:0] RAM_DATA_OUT
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_n;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wd_q;

  logic          busy_n, done_n, err_n, wr_n, oe_n;
  logic [31:0]   rdata_n, din_n;
  logic [AW-1:0] addr_n;

  logic        bad, misal;
  logic [7:0]  lane;
  logic [15:0] half;
  logic [31:0] ext, merged;
  logic        unused_addr;

  assign unused_addr = ^ADDR[31:AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = (FUNCT3[1:0] == 2'd1 && ADDR[0]) ||
                 (FUNCT3[1:0] == 2'd2 && ADDR[1:0] != 2'd0);
`else
  assign misal = 1'b0;
`endif

  assign bad = (FUNCT3 == 3'd3) || (FUNCT3[2:1] == 2'b11) ||
               (WE && FUNCT3[2]) || misal;

  // Lane/half selection and extension of the word read from RAM,
  // plus the read-modify-write merge for sub-word stores.
  always_comb begin
    lane   = 8'h00;
    half   = off_q[1] ? RAM_DATA_OUT[31:16] : RAM_DATA_OUT[15:0];
    ext    = RAM_DATA_OUT;
    merged = RAM_DATA_OUT;
    case (off_q)
      2'd0: lane = RAM_DATA_OUT[7:0];
      2'd1: lane = RAM_DATA_OUT[15:8];
      2'd2: lane = RAM_DATA_OUT[23:16];
      default: lane = RAM_DATA_OUT[31:24];
    endcase
    if (f3_q[1]) ext = RAM_DATA_OUT;
    else if (f3_q[0]) ext = {{16{half[15] & ~f3_q[2]}}, half};
    else ext = {{24{lane[7] & ~f3_q[2]}}, lane};
    if (f3_q[1:0] == 2'd0) begin
      case (off_q)
        2'd0: merged[7:0]   = wd_q[7:0];
        2'd1: merged[15:8]  = wd_q[7:0];
        2'd2: merged[23:16] = wd_q[7:0];
        default: merged[31:24] = wd_q[7:0];
      endcase
    end else if (f3_q[1:0] == 2'd1) begin
      if (off_q[1]) merged[31:16] = wd_q[15:0];
      else merged[15:0] = wd_q[15:0];
    end else begin
      merged = wd_q;
    end
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    wr_n    = 1'b0;
    oe_n    = 1'b0;
    rdata_n = RDATA;
    din_n   = RAM_DATA_IN;
    addr_n  = RAM_ADDRESS;
    unique case (state)
      IDLE: begin
        if (REQ) begin
          if (bad) begin
            state_n = RESP;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else if (!WE || FUNCT3 != 3'd2) begin
            state_n = READ;
            oe_n    = 1'b1;
            addr_n  = ADDR[AW+1:2];
          end else begin
            state_n = WRITE;
            wr_n    = 1'b1;
            addr_n  = ADDR[AW+1:2];
            din_n   = WDATA;
          end
        end
      end
      READ: begin
        if (!we_q) begin
          state_n = RESP;
          done_n  = 1'b1;
          rdata_n = ext;
        end else begin
          state_n = WRITE;
          wr_n    = 1'b1;
          din_n   = merged;
        end
      end
      WRITE: begin
        state_n = RESP;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) state <= IDLE;
    else state <= state_n;
  end

  // Request capture; only an accepted request updates these.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      we_q  <= 1'b0;
      f3_q  <= 3'd0;
      off_q <= 2'd0;
      wd_q  <= 32'd0;
    end else if (state == IDLE && REQ) begin
      we_q  <= WE;
      f3_q  <= FUNCT3;
      off_q <= ADDR[1:0];
      wd_q  <= WDATA;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      RDATA       <= 32'd0;
      RAM_WR      <= 1'b0;
      RAM_OE      <= 1'b0;
      RAM_ADDRESS <= '0;
      RAM_DATA_IN <= 32'd0;
    end else begin
      BUSY        <= busy_n;
      DONE        <= done_n;
      ERR         <= err_n;
      RDATA       <= rdata_n;
      RAM_WR      <= wr_n;
      RAM_OE      <= oe_n;
      RAM_ADDRESS <= addr_n;
      RAM_DATA_IN <= din_n;
    end
  end

endmodule

// File: tb/tb_lsu_ram_master.sv
// tb_lsu_ram_master: scoreboard bench for lsu_ram_master.
// Reference model tracks RAM contents and the last load result.
module tb_lsu_ram_master;

  logic        CLK = 1'b0;
  logic        RSTa = 1'b1;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  FUNCT3 = 3'd0;
  logic [31:0] ADDR = 32'd0;
  logic [31:0] WDATA = 32'd0;
  logic        BUSY, DONE, ERR, RAM_WR, RAM_OE;
  logic [31:0] RDATA, RAM_DATA_IN, RAM_DATA_OUT;
  logic [9:0]  RAM_ADDRESS;

  lsu_ram_master #(.TAM_POSICIONES(1024), .TAM_PALABRA(32)) dut (
    .CLK(CLK), .RSTa(RSTa), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3),
    .ADDR(ADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .RDATA(RDATA), .RAM_WR(RAM_WR), .RAM_OE(RAM_OE),
    .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATA_IN(RAM_DATA_IN),
    .RAM_DATA_OUT(RAM_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  logic [31:0] tb_ram [1024];
  assign RAM_DATA_OUT = tb_ram[RAM_ADDRESS];
  always @(posedge CLK) if (RAM_WR) tb_ram[RAM_ADDRESS] <= RAM_DATA_IN;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic        st;
    logic        access;
    logic [31:0] rdata;
    logic [31:0] wword;
    int          wi;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem_m [1024];
  logic [31:0] last_rd = 32'd0;
  int          tests = 0;
  int          fails = 0;
  logic        act = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic ref_model(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output exp_t e);
    int          sh8, sh16;
    logic [31:0] w, v, mask;
    logic        bad;
    sh8  = 8 * int'(a[1:0]);
    sh16 = a[1] ? 16 : 0;
    e = '{default: '0};
    e.wi = int'(a[11:2]);
    w = mem_m[e.wi];
    bad = (f3 == 3) || (f3 > 5) || (we && f3 > 3);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 1 || f3 == 5) && a[0]) bad = 1'b1;
    if (f3 == 2 && a[1:0] != 0) bad = 1'b1;
`endif
    if (bad) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!we) begin
      e.lat = 2;
      e.access = 1'b1;
      v = w;
      if (f3 == 0 || f3 == 4) begin
        v = (w >> sh8) & 32'd255;
        if (f3 == 0 && v >= 128) v = v - 32'd256;
      end else if (f3 == 1 || f3 == 5) begin
        v = (w >> sh16) & 32'd65535;
        if (f3 == 1 && v >= 32768) v = v - 32'd65536;
      end
      last_rd = v;
    end else begin
      e.st = 1'b1;
      e.access = 1'b1;
      if (f3 == 2) begin
        e.lat = 2;
        v = wd;
      end else if (f3 == 0) begin
        e.lat = 3;
        mask = 32'd255 << sh8;
        v = (w & ~mask) | ((wd & 32'd255) << sh8);
      end else begin
        e.lat = 3;
        mask = 32'd65535 << sh16;
        v = (w & ~mask) | ((wd & 32'd65535) << sh16);
      end
      mem_m[e.wi] = v;
      e.wword = v;
    end
    e.rdata = last_rd;
  endtask

  // Monitor: pops an expectation on every DONE and checks it.
  always @(negedge CLK) begin
    exp_t e;
    if (RSTa) begin
      if (RAM_WR && RAM_OE) begin
        fails++;
        $display("FAIL wr_oe_both: got 1, expected 0");
      end
      if (RAM_WR || RAM_OE) act = 1'b1;
      if (sbq.size() != 0 && !BUSY) begin
        fails++;
        $display("FAIL busy: got 0, expected 1 at cycle %0d", cyc);
      end
      if (DONE) begin
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL spurious_done: got DONE, expected none");
        end else begin
          e = sbq.pop_front();
          chk("err", {31'd0, ERR}, {31'd0, e.err});
          chk("rdata", RDATA, e.rdata);
          chk("latency", cyc, e.issue + e.lat - 1);
          chk("ram_access", {31'd0, act}, {31'd0, e.access});
          if (e.st) chk("ram_word", tb_ram[e.wi], e.wword);
        end
        act = 1'b0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    @(negedge CLK);
    REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = a; WDATA = wd;
    ref_model(we, f3, a, wd, e);
    @(posedge CLK); #1;
    REQ = 1'b0;
    e.issue = cyc;
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge CLK); #1;
      n++;
    end while ((sbq.size() != 0 || BUSY) && n < 30);
    if (sbq.size() != 0 || BUSY) begin
      tests++;
      fails++;
      $display("FAIL timeout: got busy after %0d cycles, expected idle", n);
      sbq.delete();
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    issue(we, f3, a, wd);
    wait_idle();
  endtask

  initial begin
    exp_t        e;
    logic [31:0] r, wd;
    logic [2:0]  w3;
    logic [1:0]  off;

    #3 RSTa = 1'b0;
    #9;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_wr_oe", {30'd0, RAM_WR, RAM_OE}, 32'd0);
    chk("rst_addr", {22'd0, RAM_ADDRESS}, 32'd0);
    chk("rst_din", RAM_DATA_IN, 32'd0);
    @(negedge CLK); RSTa = 1'b1;

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'd0);
    chk("lw_deadbeef", RDATA, 32'hDEADBEEF);
    chk("sw_word4", tb_ram[4], 32'hDEADBEEF);

    do_req(1'b1, 3'd2, 32'h10, 32'h11223344);
    do_req(1'b1, 3'd0, 32'h12, 32'h000000AA);
    chk("sb_merge", tb_ram[4], 32'h11AA3344);
    do_req(1'b0, 3'd0, 32'h12, 32'd0);
    chk("lb_sext", RDATA, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 32'h12, 32'd0);
    chk("lbu_zext", RDATA, 32'h000000AA);

    do_req(1'b1, 3'd2, 32'h10, 32'h80017FFF);
    do_req(1'b0, 3'd1, 32'h12, 32'd0);
    chk("lh_sext", RDATA, 32'hFFFF8001);
    do_req(1'b0, 3'd5, 32'h12, 32'd0);
    chk("lhu_zext", RDATA, 32'h00008001);
    do_req(1'b0, 3'd1, 32'h10, 32'd0);
    chk("lh_pos", RDATA, 32'h00007FFF);

    do_req(1'b0, 3'd2, 32'h13, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_hold", RDATA, 32'h00007FFF);
`else
    chk("lw_mis_word", RDATA, 32'h80017FFF);
`endif
    do_req(1'b0, 3'd3, 32'h10, 32'd0);
    do_req(1'b1, 3'd4, 32'h10, 32'h55);
    chk("bad_f3_ram", tb_ram[4], 32'h80017FFF);

    for (int i = 0; i < 8; i++) do_req(1'b1, 3'd2, 32'(i * 4), $urandom());

    // Second request held on REQ while busy must be ignored.
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'd2; ADDR = 32'h0; WDATA = 32'd0;
    ref_model(1'b0, 3'd2, 32'h0, 32'd0, e);
    @(posedge CLK); #1;
    e.issue = cyc;
    sbq.push_back(e);
    WE = 1'b1; ADDR = 32'h1C; WDATA = 32'h12345678;
    repeat (2) @(posedge CLK);
    #1 REQ = 1'b0;
    wait_idle();
    chk("held_req_w7", tb_ram[7], mem_m[7]);
    chk("held_req_rd", RDATA, mem_m[0]);

    // Reset in the middle of a word write.
    do_req(1'b1, 3'd2, 32'h14, 32'h00000055);
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'd2; ADDR = 32'h14;
    WDATA = 32'hBADBAD00;
    @(posedge CLK); #2;
    REQ = 1'b0;
    chk("pre_rst_wr", {31'd0, RAM_WR}, 32'd1);
    RSTa = 1'b0;
    #1;
    chk("mid_rst_wr", {31'd0, RAM_WR}, 32'd0);
    chk("mid_rst_flags", {28'd0, BUSY, DONE, ERR, RAM_OE}, 32'd0);
    chk("mid_rst_rdata", RDATA, 32'd0);
    chk("mid_rst_addr", {22'd0, RAM_ADDRESS}, 32'd0);
    chk("mid_rst_din", RAM_DATA_IN, 32'd0);
    @(posedge CLK); #1;
    chk("mid_rst_ram", tb_ram[5], 32'h00000055);
    @(negedge CLK);
    RSTa = 1'b1;
    act = 1'b0;
    last_rd = 32'd0;

    for (int i = 0; i < 300; i++) begin
      r   = $urandom();
      wd  = $urandom();
      w3  = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      do_req(r[0], 3'($urandom_range(0, 7)),
             {r[31:12], 7'd0, w3, off}, wd);
    end
    for (int i = 0; i < 8; i++) chk("final_ram", tb_ram[i], mem_m[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ram_master.md
# lsu_ram_master

Load/store master that drives the word-organised data RAM on behalf of the RISC-V core's memory stage. It accepts one byte-addressed load or store per request, performs word reads, sign/zero extension, and read-modify-write for sub-word stores. It is the initiator side of the RAM's WR/OE/ADDRESS/DATA_IN/DATA_OUT interface.

## Interface
- TAM_POSICIONES, 1024, number of RAM words; sets RAM_ADDRESS width to $clog2(TAM_POSICIONES)
- TAM_PALABRA, 32, RAM word width; only 32 is supported
- CLK  in  1  clock, rising edge
- RSTa  in  1  asynchronous, active-low reset
- REQ  in  1  request strobe from core; sampled only in IDLE
- WE  in  1  1 = store, 0 = load
- FUNCT3  in  3  RV32I funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- ADDR  in  32  byte address
- WDATA  in  32  store data; low byte/half used for SB/SH
- BUSY  out  1  request in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE; access was rejected
- RDATA  out  32  extended load result
- RAM_WR  out  1  RAM write enable
- RAM_OE  out  1  RAM output enable
- RAM_ADDRESS  out  $clog2(TAM_POSICIONES)  word address = ADDR[$clog2(TAM_POSICIONES)+1:2]; upper ADDR bits ignored
- RAM_DATA_IN  out  32  word written to RAM
- RAM_DATA_OUT  in  32  word read from RAM

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: if REQ=1, register WE, FUNCT3, ADDR, WDATA, then:
  - invalid funct3 (3, 6, 7; or 4/5 with WE=1) -> RESP with ERR=1, no RAM access;
  - misaligned (see Configuration) -> RESP with ERR=1, no RAM access;
  - load or SB/SH -> READ;
  - SW -> WRITE.
- READ: RAM_OE=1, RAM_WR=0; RAM_DATA_OUT captured on the exiting edge. For a load, go to RESP. For SB/SH, go to WRITE.
- WRITE: RAM_WR=1, RAM_OE=0, RAM_DATA_IN is:
  - SW: WDATA;
  - SB: captured word with lane ADDR[1:0] replaced by WDATA[7:0];
  - SH: captured word with half ADDR[1] replaced by WDATA[15:0].
- Then go to RESP.
- RESP: DONE=1 for one cycle, then IDLE.
- Load extraction: LB/LBU take byte lane ADDR[1:0]; LH/LHU take half ADDR[1]; LB/LH sign-extend, LBU/LHU zero-extend.
- RDATA updates only at load completion and holds otherwise. Stores and errors leave RDATA unchanged.
- RAM_WR and RAM_OE are never both 1. All outputs are registered.
- REQ outside IDLE (including during RESP) is ignored; the core must hold or re-issue it.

## Timing
- Reset values: BUSY=0, DONE=0, ERR=0, RDATA=0, RAM_WR=0, RAM_OE=0, RAM_ADDRESS=0, RAM_DATA_IN=0, state IDLE.
- REQ sampled high at edge e0. BUSY=1 from e0 until DONE falls.
- Latency from e0 to the DONE cycle:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- Throughput: the next request is accepted at the earliest on the edge ending the cycle after DONE.
- RAM_ADDRESS is stable throughout READ and WRITE. RAM samples the write on the edge ending WRITE.
- Reset mid-operation: all outputs return to reset values immediately, so an in-flight write is suppressed. Sub-word RMW may leave the RAM unmodified but never partially written.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with ADDR[0]=1 are errors;
  - LW/SW with ADDR[1:0]≠0 are errors.
- Undefined:
  - misaligned half accesses use ADDR[1] only, ignoring ADDR[0];
  - word accesses ignore ADDR[1:0];
  - ERR is asserted only for invalid funct3.

## Test plan
- Reset with RSTa=0 mid-WRITE -> RAM_WR drops to 0 asynchronously; word at that address is unchanged; all outputs at reset values.
- SW ADDR=0x10, WDATA=0xDEADBEEF, then LW ADDR=0x10 -> RAM word 4 = 0xDEADBEEF; RDATA=0xDEADBEEF; each DONE 2 cycles after REQ.
- Preload word 4 with 0x11223344; SB ADDR=0x12, WDATA=0xAA -> DONE 3 cycles after REQ, word 4 = 0x11AA3344; then LB 0x12 -> 0xFFFFFFAA; LBU 0x12 -> 0x000000AA.
- Word 4 = 0x80017FFF: LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001; LH 0x10 -> 0x00007FFF.
- With LSU_MISALIGN_TRAP_EN, LW 0x13 -> DONE+ERR one cycle after REQ; RAM_OE/RAM_WR stay 0; RDATA unchanged. Without the macro, the same request returns word 4.
- REQ held high during BUSY, and FUNCT3=3 requests -> extra requests not accepted until IDLE; FUNCT3=3 gives ERR=1 with no RAM activity.
